instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the fetch address loaded on reset (bits [1:0] ignored, treated as 0).
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset: asserted when 0, acting immediately without a clock edge.
REQ-004 fetch_en  input  1  PE enable; fetching permitted while 1.
REQ-005 stall  input  1  downstream instruction register cannot accept a new word this cycle.
REQ-006 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] forced to 0.
REQ-008 imem_req  output  1  memory read request, registered.
REQ-009 imem_addr  output  32  word-aligned read address, registered.
REQ-010 imem_ready  input  1  memory accepts request this cycle.
REQ-011 imem_rvalid  input  1  read data valid this cycle.
REQ-012 imem_rdata  input  32  read data.
REQ-013 ir_data  output  32  instruction word for the instruction register data_in, registered.
REQ-014 ir_load  output  1  one-cycle load pulse for the instruction register enable, registered.
REQ-015 pc_out  output  32  address of the word currently on ir_data, registered.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 Block SHALL implement FSM states IDLE, REQ, WAIT, HOLD, with a 32-bit pc register, a 32-bit hold buffer and a kill flag.
REQ-018 IDLE: imem_req=0; fetch_en=1 -> REQ next cycle.
REQ-019 REQ: imem_req=1, imem_addr=pc; imem_ready=1 -> WAIT; imem_req and imem_addr SHALL stay stable until accepted.
REQ-020 WAIT: imem_req=0; awaits exactly one imem_rvalid; only one request SHALL be outstanding at any time.
REQ-021 WAIT, rvalid=1, stall=0, no kill: next cycle ir_load=1, ir_data=imem_rdata, pc_out=pc; pc += 4; next state REQ if fetch_en=1, else IDLE.
REQ-022 WAIT, rvalid=1, stall=1, no kill: hold buffer captures imem_rdata; next state HOLD; ir_load stays 0.
REQ-023 HOLD: on the first cycle with stall=0, next cycle ir_load=1, ir_data=hold buffer, pc_out=pc; pc += 4; next state REQ if fetch_en=1, else IDLE.
REQ-024 Latency: ir_load SHALL rise exactly one cycle after the accepting rvalid cycle (or the stall-release cycle); minimum 3 cycles from request issue to ir_load.
REQ-025 ir_load SHALL be a single-cycle pulse; ir_data and pc_out SHALL hold their value when ir_load=0.
REQ-026 pc addition SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 Redirect in IDLE or REQ: pc <= {redirect_pc[31:2],2'b00}; next state REQ, including while imem_req=1 and not yet accepted.
REQ-028 Redirect in WAIT, or in the REQ cycle where imem_ready=1: set kill and load pc; the pending response SHALL be discarded (no ir_load), kill cleared, next state REQ.
REQ-029 Redirect coincident with rvalid in WAIT: that response SHALL be discarded and next state SHALL be REQ at the redirect address.
REQ-030 Redirect in HOLD: hold buffer discarded, no ir_load, next state REQ at the redirect address.
REQ-031 fetch_en falling SHALL NOT abort an in-flight request; the fetch completes and then the FSM goes to IDLE.
REQ-032 rvalid outside WAIT SHALL be ignored.

Reset
REQ-033 reset=0 SHALL force state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir_load=0, ir_data=0, pc_out=0, kill=0, hold buffer=0, including mid-transaction.
REQ-034 After reset release, the first request SHALL be issued no earlier than one cycle after fetch_en is sampled high.

Verification
REQ-035 Reset, fetch_en=1, memory ready=1, rvalid one cycle later with data 32'h0000_0013 -> imem_addr=0, 4, 8 on successive requests; ir_load pulses carry 32'h13 with pc_out 0, 4, 8.
REQ-036 stall=1 for 3 cycles when rvalid returns 32'hDEADBEEF -> no ir_load during stall; single ir_load with 32'hDEADBEEF one cycle after stall falls; no new request while in HOLD.
REQ-037 redirect_valid with redirect_pc=32'h0000_0103 during WAIT -> in-flight word dropped, next imem_addr=32'h0000_0100, no spurious ir_load.
REQ-038 pc preset via redirect to 32'hFFFF_FFFC -> after that fetch, next imem_addr=32'h0000_0000.
REQ-039 reset asserted in WAIT, with rvalid arriving during reset -> all outputs zero immediately, ir_load never pulses, fetch restarts at RESET_PC.
REQ-040 imem_ready held 0 for 5 cycles -> imem_req and imem_addr stable throughout; busy=1.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch engine. It issues one word-aligned read at a time to
//   instruction memory. It forwards each returned word to the instruction
//   register with a single-cycle load pulse and the word's address. It parks
//   a word in a hold buffer while the instruction register is stalled.
//   Redirects restart fetch at a new address. A response that is already in
//   flight when a redirect arrives is discarded through the kill flag.
//
// Ports
//   clk_i             system clock, rising edge
//   rst_ni            asynchronous active-low reset
//   fetch_en_i        fetching permitted while high
//   stall_i           instruction register cannot accept a word this cycle
//   redirect_valid_i  one-cycle request to restart fetch at redirect_pc_i
//   redirect_pc_i     new fetch address (bits [1:0] ignored)
//   imem_req_o        memory read request (registered)
//   imem_addr_o       word-aligned read address (registered)
//   imem_ready_i      memory accepts the request this cycle
//   imem_rvalid_i     read data valid this cycle
//   imem_rdata_i      read data
//   ir_data_o         instruction word for the instruction register
//   ir_load_o         one-cycle load pulse for the instruction register
//   pc_out_o          address of the word currently on ir_data_o
//   busy_o            high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_en_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] ir_data_o,
    output logic        ir_load_o,
    output logic [31:0] pc_out_o,
    output logic        busy_o
);

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic        kill_q, kill_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_data_q, ir_data_d;
    logic        ir_load_q, ir_load_d;
    logic [31:0] pc_out_q, pc_out_d;

    logic [31:0] redir_pc;
    logic        deliver;
    logic [31:0] deliver_data;

    // Masking keeps every bit of the input in use while forcing word alignment.
    assign redir_pc = redirect_pc_i & ~32'd3;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        kill_d       = kill_q;
        ir_load_d    = 1'b0;
        ir_data_d    = ir_data_q;
        pc_out_d     = pc_out_q;
        deliver      = 1'b0;
        deliver_data = imem_rdata_i;

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    state_d = S_REQ;
                end else if (fetch_en_i) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect_valid_i) begin
                    pc_d = redir_pc;
                    // Accepted in the same cycle: its response is stale and
                    // must be swallowed before the new request goes out.
                    if (imem_ready_i) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_valid_i || kill_q) begin
                        kill_d  = 1'b0;
                        if (redirect_valid_i) begin
                            pc_d = redir_pc;
                        end
                        state_d = S_REQ;
                    end else if (stall_i) begin
                        hold_d  = imem_rdata_i;
                        state_d = S_HOLD;
                    end else begin
                        deliver      = 1'b1;
                        deliver_data = imem_rdata_i;
                    end
                end else if (redirect_valid_i) begin
                    // Stay here until the outstanding response drains.
                    pc_d   = redir_pc;
                    kill_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    hold_d  = '0;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    deliver      = 1'b1;
                    deliver_data = hold_q;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (deliver) begin
            ir_load_d = 1'b1;
            ir_data_d = deliver_data;
            pc_out_d  = pc_q;
            pc_d      = pc_q + 32'd4;
            state_d   = fetch_en_i ? S_REQ : S_IDLE;
        end
    end

    // Request outputs are registered from the next state, so they track
    // the REQ state and the current pc exactly.
    assign req_d  = (state_d == S_REQ);
    assign addr_d = pc_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC_AL;
            hold_q    <= '0;
            kill_q    <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC_AL;
            ir_data_q <= '0;
            ir_load_q <= 1'b0;
            pc_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            kill_q    <= kill_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ir_data_q <= ir_data_d;
            ir_load_q <= ir_load_d;
            pc_out_q  <= pc_out_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign ir_data_o   = ir_data_q;
    assign ir_load_o   = ir_load_q;
    assign pc_out_o    = pc_out_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
